// File: rtl/prio_enc_pkg.sv
// Shared definitions for the draining priority encoder and its selector.
package prio_enc_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_t;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

endpackage

// File: rtl/prio_sel.sv
// Combinational selector: picks the next set bit of pend, either highest-first
// or descending from just below ptr with wrap, and flags the last set bit.
module prio_sel
  import prio_enc_pkg::*;
#(
  parameter int N    = 8,
  parameter int MODE = MODE_FIXED,
  localparam int W   = $clog2(N)
) (
  input  logic [N-1:0] pend,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         last
);

  int     start;
  int     pos;
  logic   found;
  logic [W:0] cnt;

  // The wrap is done in integer arithmetic so a non-power-of-2 N never yields an index >= N.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    start = 0;
    pos   = 0;
    if (MODE == MODE_RR) begin
      start = (ptr == '0) ? N - 1 : int'(ptr) - 1;
      for (int k = 0; k < N; k++) begin
        pos = start - k;
        if (pos < 0) pos = pos + N;
        if (!found && pend[pos[W-1:0]]) begin
          idx   = W'(pos);
          found = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (pend[i]) idx = W'(i);
      end
    end
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < N; i++) cnt = cnt + (W+1)'(pend[i]);
    last = (cnt == (W+1)'(1));
  end

endmodule

// File: rtl/prio_enc_drain.sv
// Captures a request vector and drains its set bits one index per output
// handshake; an all-zero vector is reported as a one-cycle none pulse.
module prio_enc_drain
  import prio_enc_pkg::*;
#(
  parameter int N    = 8,
  parameter int MODE = MODE_FIXED,
  localparam int W   = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         req_valid,
  output logic         req_ready,
  output logic [W-1:0] out_idx,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         none
);

  state_t       state;
  logic [N-1:0] pend;
  logic [W-1:0] ptr;
  logic [W-1:0] sel_idx;
  logic         sel_last;

  prio_sel #(
    .N    (N),
    .MODE (MODE)
  ) u_sel (
    .pend (pend),
    .ptr  (ptr),
    .idx  (sel_idx),
    .last (sel_last)
  );

  // In fixed mode ptr is never written, so it stays at its reset value of 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pend  <= '0;
      ptr   <= '0;
      none  <= 1'b0;
    end else begin
      none <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (req == '0) begin
              none <= 1'b1;
            end else begin
              pend  <= req;
              state <= SERVE;
            end
          end
        end
        SERVE: begin
          if (out_ready) begin
            pend <= pend & ~(N'(1) << sel_idx);
            if (MODE == MODE_RR) ptr <= sel_idx;
            if (sel_last) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready = (state == IDLE);
  assign out_valid = (state == SERVE);
  assign out_idx   = (state == SERVE) ? sel_idx : '0;
  assign out_last  = (state == SERVE) && sel_last;

endmodule

// File: tb/tb_prio_enc_drain.sv
// Bench for prio_enc_drain: five instances (4/fixed, 4/rr, 8/fixed, 8/rr, 5/rr)
// driven from a vector table with an expected-grant queue, plus a mid-drain reset.
module tb_prio_enc_drain;

  localparam int ND = 5;
  localparam int NS [ND] = '{4, 4, 8, 8, 5};
  localparam int MS [ND] = '{0, 1, 0, 1, 1};

  logic          clk;
  logic          rst;
  logic [7:0]    req;
  logic [ND-1:0] rv;
  logic          out_ready;
  logic [ND-1:0] rdy, vld, lst, non;
  logic [2:0]    idxA [ND];

  int   sel;
  logic curRdy, curVld, curLst, curNon;
  logic [2:0] curIdx;

  int nAssert = 0;
  int nFail   = 0;

  typedef struct {
    int   idx;
    bit   last;
  } exp_t;
  exp_t expQ[$];

  // ord holds the expected grant order, first grant in the lowest nibble.
  typedef struct {
    int             dut;
    logic [7:0]     vec;
    int             stall;
    int             cnt;
    logic [7:0][3:0] ord;
  } vec_t;
  vec_t tbl [10];

  for (genvar g = 0; g < ND; g++) begin : g_dut
    localparam int NN = NS[g];
    logic [$clog2(NN)-1:0] oi;
    prio_enc_drain #(
      .N    (NN),
      .MODE (MS[g])
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req[NN-1:0]),
      .req_valid (rv[g]),
      .req_ready (rdy[g]),
      .out_idx   (oi),
      .out_valid (vld[g]),
      .out_ready (out_ready),
      .out_last  (lst[g]),
      .none      (non[g])
    );
    assign idxA[g] = 3'(oi);
  end

  always_comb begin
    curRdy = rdy[sel];
    curVld = vld[sel];
    curLst = lst[sel];
    curNon = non[sel];
    curIdx = idxA[sel];
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    nAssert++;
    if (act != exp) begin
      nFail++;
      $display("[TB] FAIL %s (dut %0d): got %0d, expected %0d", name, sel, act, exp);
    end
  endtask

  // Entered and left at #1 after a rising edge; the accept happens on the edge in between.
  task automatic applyStimulus(input int dut, input logic [7:0] vec);
    sel = dut;
    #0;
    checkOutput("accept_ready", curRdy, 1);
    req = vec;
    rv  = ND'(1) << dut;
    @(posedge clk);
    #1;
    rv  = '0;
    req = '0;
  endtask

  task automatic drainQueue(input int budget);
    exp_t e;
    int   guard;
    guard = 0;
    while (expQ.size() > 0 && guard < budget) begin
      @(negedge clk);
      guard++;
      if (curVld) begin
        e = expQ.pop_front();
        checkOutput("grant_idx", curIdx, e.idx);
        checkOutput("grant_last", curLst, e.last);
        checkOutput("serve_ready", curRdy, 0);
      end
      @(posedge clk);
      #1;
    end
    checkOutput("drain_left", expQ.size(), 0);
    expQ.delete();
  endtask

  task automatic runVector(input vec_t v);
    for (int k = 0; k < v.cnt; k++)
      expQ.push_back('{idx: int'(v.ord[k]), last: (k == v.cnt - 1)});
    applyStimulus(v.dut, v.vec);
    if (v.cnt == 0) begin
      checkOutput("none_pulse", curNon, 1);
      checkOutput("none_valid", curVld, 0);
      checkOutput("none_ready", curRdy, 1);
      @(posedge clk);
      #1;
      checkOutput("none_clear", curNon, 0);
      checkOutput("none_valid2", curVld, 0);
    end else begin
      out_ready = 1'b0;
      for (int s = 0; s < v.stall; s++) begin
        @(negedge clk);
        checkOutput("stall_valid", curVld, 1);
        checkOutput("stall_idx", curIdx, expQ[0].idx);
        @(posedge clk);
        #1;
      end
      out_ready = 1'b1;
      drainQueue(20);
      out_ready = 1'b0;
      checkOutput("post_ready", curRdy, 1);
      checkOutput("post_valid", curVld, 0);
      checkOutput("post_idx", curIdx, 0);
      checkOutput("post_last", curLst, 0);
    end
  endtask

  initial begin
    exp_t e;
    tbl[0] = '{dut: 0, vec: 8'h0B, stall: 0, cnt: 3, ord: 32'h0000_0013};
    tbl[1] = '{dut: 0, vec: 8'h00, stall: 0, cnt: 0, ord: 32'h0};
    tbl[2] = '{dut: 0, vec: 8'h0F, stall: 2, cnt: 4, ord: 32'h0000_0123};
    tbl[3] = '{dut: 2, vec: 8'h90, stall: 5, cnt: 2, ord: 32'h0000_0047};
    tbl[4] = '{dut: 2, vec: 8'h01, stall: 0, cnt: 1, ord: 32'h0};
    tbl[5] = '{dut: 1, vec: 8'h04, stall: 0, cnt: 1, ord: 32'h0000_0002};
    tbl[6] = '{dut: 1, vec: 8'h0D, stall: 0, cnt: 3, ord: 32'h0000_0230};
    tbl[7] = '{dut: 4, vec: 8'h11, stall: 0, cnt: 2, ord: 32'h0000_0004};
    tbl[8] = '{dut: 4, vec: 8'h11, stall: 1, cnt: 2, ord: 32'h0000_0004};
    tbl[9] = '{dut: 2, vec: 8'h00, stall: 0, cnt: 0, ord: 32'h0};

    sel       = 0;
    rst       = 1'b1;
    req       = '0;
    rv        = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) begin
      sel = d;
      #0;
      checkOutput("reset_ready", curRdy, 1);
      checkOutput("reset_valid", curVld, 0);
      checkOutput("reset_idx", curIdx, 0);
      checkOutput("reset_last", curLst, 0);
      checkOutput("reset_none", curNon, 0);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) runVector(tbl[i]);

    // Reset in the middle of a round-robin drain must discard the vector and the pointer.
    for (int k = 7; k >= 5; k--) expQ.push_back('{idx: k, last: 1'b0});
    applyStimulus(3, 8'hFF);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("rr_valid", curVld, 1);
      e = expQ.pop_front();
      checkOutput("rr_idx", curIdx, e.idx);
      checkOutput("rr_last", curLst, e.last);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b0;
    rst       = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rst_mid_valid", curVld, 0);
    checkOutput("rst_mid_ready", curRdy, 1);
    checkOutput("rst_mid_idx", curIdx, 0);
    checkOutput("rst_mid_last", curLst, 0);
    runVector('{dut: 3, vec: 8'h81, stall: 0, cnt: 2, ord: 32'h0000_0007});

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
